// File: rtl/pulse_shaper.sv
// pulse_shaper
//   Turns each rising edge on trig into an output pulse that is high for
//   exactly MIN_HIGH cycles and then low for at least MIN_LOW cycles, so it
//   survives a downstream inertial filter of either width. Edges that arrive
//   while a pulse or gap is in progress are queued in a saturating counter and
//   replayed in order. All outputs are flop outputs.
//
// Ports
//   clk       single clock, rising edge
//   rst       synchronous, active-high reset
//   trig      event input; a sampled 0->1 transition is one event
//   pulse     shaped output pulse
//   busy      1 while a pulse or its trailing gap is in progress
//   pend_cnt  number of queued events not yet emitted
//   overflow  sticky flag: an event was lost with the queue full
module pulse_shaper #(
    parameter int MIN_HIGH = 5,
    parameter int MIN_LOW  = 5,
    parameter int PEND_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig,
    output logic              pulse,
    output logic              busy,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              overflow
);

    localparam int CNT_MAX = (MIN_HIGH > MIN_LOW) ? MIN_HIGH : MIN_LOW;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(MIN_HIGH - 1);
    localparam logic [CNT_W-1:0]  LOW_LOAD  = CNT_W'(MIN_LOW - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
    localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               trig_d_r;

    logic               ev_s;
    logic               start_s;
    logic               deq_s;
    logic               enq_s;
    logic [PEND_W-1:0]  pend_nxt_s;
    logic               ovf_set_s;

    // Edge detect and per-state start / dequeue / enqueue decisions.
    always_comb begin
        ev_s    = trig & ~trig_d_r;
        start_s = 1'b0;
        deq_s   = 1'b0;
        enq_s   = 1'b0;
        case (state_r)
            IDLE: begin
                // A leftover queued event (from an edge that landed on the
                // GAP->IDLE edge) is served first; a fresh edge then queues.
                start_s = ev_s | (pend_cnt != '0);
                deq_s   = (pend_cnt != '0);
                enq_s   = ev_s & (pend_cnt != '0);
            end
            HIGH: begin
                enq_s = ev_s;
            end
            GAP: begin
                start_s = (cnt_r == '0) && (pend_cnt != '0);
                deq_s   = (cnt_r == '0) && (pend_cnt != '0);
                enq_s   = ev_s;
            end
            default: begin
                start_s = 1'b0;
                deq_s   = 1'b0;
                enq_s   = 1'b0;
            end
        endcase
    end

    // Pending-queue next value; a same-edge enqueue and dequeue cancel out,
    // so an event arriving at saturation alongside a dequeue is not lost.
    always_comb begin
        pend_nxt_s = pend_cnt;
        ovf_set_s  = 1'b0;
        if (enq_s && !deq_s) begin
            if (pend_cnt == PEND_MAX) begin
                ovf_set_s = 1'b1;
            end else begin
                pend_nxt_s = pend_cnt + PEND_ONE;
            end
        end else if (deq_s && !enq_s) begin
            pend_nxt_s = pend_cnt - PEND_ONE;
        end else begin
            pend_nxt_s = pend_cnt;
        end
    end

    // Main FSM with registered pulse/busy/queue/overflow outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            trig_d_r <= 1'b1;   // trig held high through reset is not an event
            pulse    <= 1'b0;
            busy     <= 1'b0;
            pend_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            trig_d_r <= trig;
            pend_cnt <= pend_nxt_s;
            overflow <= overflow | ovf_set_s;
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        state_r <= HIGH;
                        cnt_r   <= HIGH_LOAD;
                        pulse   <= 1'b1;
                        busy    <= 1'b1;
                    end else begin
                        pulse   <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                HIGH: begin
                    busy <= 1'b1;
                    if (cnt_r == '0) begin
                        state_r <= GAP;
                        cnt_r   <= LOW_LOAD;
                        pulse   <= 1'b0;
                    end else begin
                        cnt_r   <= cnt_r - CNT_ONE;
                        pulse   <= 1'b1;
                    end
                end
                GAP: begin
                    if (start_s) begin
                        state_r <= HIGH;
                        cnt_r   <= HIGH_LOAD;
                        pulse   <= 1'b1;
                        busy    <= 1'b1;
                    end else if (cnt_r != '0) begin
                        cnt_r   <= cnt_r - CNT_ONE;
                        pulse   <= 1'b0;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        pulse   <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    pulse   <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_shaper.sv
// Directed bench for pulse_shaper with default parameters
// (MIN_HIGH=5, MIN_LOW=5, PEND_W=3). Inputs change 1 time unit after a rising
// edge; outputs are sampled at that same point, so each sample reflects the
// edge just taken.
module tb_pulse_shaper;

    logic       clk;
    logic       rst;
    logic       trig;
    logic       pulse;
    logic       busy;
    logic [2:0] pend_cnt;
    logic       overflow;

    int checks;
    int failures;

    int   rises;
    int   hi;
    int   bz;
    int   maxp;
    logic prev_pulse;

    pulse_shaper #(
        .MIN_HIGH(5),
        .MIN_LOW (5),
        .PEND_W  (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .trig    (trig),
        .pulse   (pulse),
        .busy    (busy),
        .pend_cnt(pend_cnt),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic acc_clear();
        rises = 0;
        hi    = 0;
        bz    = 0;
        maxp  = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (pulse && !prev_pulse) rises++;
        if (pulse) hi++;
        if (busy) bz++;
        if (int'(pend_cnt) > maxp) maxp = int'(pend_cnt);
        prev_pulse = pulse;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        prev_pulse = 1'b0;
        acc_clear();
        rst  = 1'b1;
        trig = 1'b0;

        // Reset state
        tick_n(2);
        check("rst_pulse", pulse, 0);
        check("rst_busy", busy, 0);
        check("rst_pend", pend_cnt, 0);
        check("rst_ovf", overflow, 0);
        rst = 1'b0;
        tick();

        // Single event with trig held high for 20 cycles
        trig = 1'b1;
        tick();
        check("single_first_high", pulse, 1);
        check("single_busy", busy, 1);
        acc_clear();
        tick_n(4);
        check("single_hi_4_more", hi, 4);
        tick();
        check("single_pulse_end", pulse, 0);
        check("single_gap_busy", busy, 1);
        acc_clear();
        tick_n(4);
        check("single_gap_busy_cnt", bz, 4);
        tick();
        check("single_idle", busy, 0);
        tick_n(9);
        trig = 1'b0;
        acc_clear();
        tick_n(10);
        check("single_no_extra", rises, 0);

        // One-cycle glitch
        acc_clear();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        tick_n(14);
        check("glitch1_rises", rises, 1);
        check("glitch1_hi", hi, 5);
        check("glitch1_busy", bz, 10);

        // Three-cycle trig
        acc_clear();
        trig = 1'b1;
        tick_n(3);
        trig = 1'b0;
        tick_n(12);
        check("glitch3_rises", rises, 1);
        check("glitch3_hi", hi, 5);
        check("glitch3_busy", bz, 10);

        // Burst: 4 one-cycle pulses, 2 cycles apart
        acc_clear();
        for (int i = 0; i < 4; i++) begin
            trig = 1'b1;
            tick();
            trig = 1'b0;
            tick();
        end
        check("burst_pend_peak", pend_cnt, 3);
        tick_n(3);
        check("burst_2nd_start", pulse, 1);
        check("burst_pend_after_deq", pend_cnt, 2);
        tick_n(30);
        check("burst_busy_end", busy, 0);
        check("burst_pend_end", pend_cnt, 0);
        check("burst_rises", rises, 4);
        check("burst_hi", hi, 20);
        check("burst_busy_cnt", bz, 40);
        check("burst_maxp", maxp, 3);

        // Overflow: 10 events, 2 cycles apart; one is dropped at saturation
        acc_clear();
        for (int i = 0; i < 10; i++) begin
            trig = 1'b1;
            tick();
            trig = 1'b0;
            tick();
        end
        check("ovf_pend_sat", pend_cnt, 7);
        check("ovf_flag", overflow, 1);
        tick_n(80);
        check("ovf_rises", rises, 9);
        check("ovf_hi", hi, 45);
        check("ovf_busy_cnt", bz, 90);
        check("ovf_maxp", maxp, 7);
        check("ovf_pend_end", pend_cnt, 0);
        check("ovf_sticky", overflow, 1);
        rst = 1'b1;
        tick();
        check("ovf_cleared_by_rst", overflow, 0);
        rst = 1'b0;
        tick();

        // Event on the GAP->IDLE edge is queued and served one cycle later
        acc_clear();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        tick_n(9);
        trig = 1'b1;
        tick();
        check("gapidle_pend", pend_cnt, 1);
        check("gapidle_busy", busy, 0);
        check("gapidle_pulse", pulse, 0);
        trig = 1'b0;
        tick();
        check("gapidle_restart", pulse, 1);
        check("gapidle_pend_taken", pend_cnt, 0);
        check("gapidle_hi", hi, 6);
        tick_n(12);
        check("gapidle_done", busy, 0);

        // Event on the GAP->HIGH edge with one queued event
        acc_clear();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        tick();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        tick_n(7);
        trig = 1'b1;
        tick();
        check("gaphigh_pulse", pulse, 1);
        check("gaphigh_pend_held", pend_cnt, 1);
        trig = 1'b0;
        tick_n(20);
        check("gaphigh_busy_end", busy, 0);
        check("gaphigh_pend_end", pend_cnt, 0);
        check("gaphigh_rises", rises, 3);

        // Reset mid-pulse with trig held high
        trig = 1'b1;
        tick();
        tick_n(2);
        check("midrst_3rd_high", pulse, 1);
        rst = 1'b1;
        tick();
        check("midrst_pulse", pulse, 0);
        check("midrst_busy", busy, 0);
        check("midrst_pend", pend_cnt, 0);
        rst = 1'b0;
        acc_clear();
        tick_n(6);
        check("midrst_no_pulse", rises, 0);
        check("midrst_no_busy", bz, 0);
        trig = 1'b0;
        tick();
        trig = 1'b1;
        tick();
        check("midrst_new_edge", pulse, 1);
        trig = 1'b0;
        tick_n(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
